// File: rtl/dram_pattern_tester.sv
// dram_pattern_tester: writes a generated pattern to a block of lines, reads it back and counts mismatches
module dram_pattern_tester #(
  parameter int          ADDR_W      = 26,
  parameter int          DATA_W      = 256,
  parameter int          NUM_LINES   = 16,
  parameter int          START_DELAY = 8191,
  parameter int          MAX_OUT     = 4,
  parameter logic [31:0] SEED        = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req_val,
  input  logic              mem_req_rdy,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_resp_val,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  localparam int DW = $clog2(START_DELAY + 2);
  localparam logic [15:0] LAST = 16'(NUM_LINES - 1);
  typedef enum logic [2:0] {IDLE, DELAY, WRITE, READ, DRAIN, FINISH} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [15:0] idx, idx_n, rcnt, rcnt_n, err_n;
  logic [3:0] outst, outst_n;
  logic val_n, rw_n;
  logic [ADDR_W-1:0] addr_n, fea_n, base_r, base_n;
  logic [DATA_W-1:0] data_n;
  logic [1:0] mode_r, mode_n;
  logic acc, rd_acc, resp_take, last_i, mismatch;
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [15:0] i);
    logic [31:0] w;
    w = (m == 2'd3) ? (32'(i) * 32'h9E3779B9) ^ SEED : 32'(i) + SEED;
    return (m == 2'd1) ? DATA_W'(1) << (32'(i) % 32'(DATA_W)) :
           (m == 2'd2) ? ~{(DATA_W/32){w}} : {(DATA_W/32){w}};
  endfunction
  assign acc       = mem_req_val && mem_req_rdy;
  assign rd_acc    = acc && state == READ;
  assign resp_take = mem_resp_val && (state == READ || state == DRAIN);
  assign last_i    = idx == LAST;
  assign mismatch  = resp_take && mem_resp_data != pat(mode_r, rcnt);
  assign busy      = state inside {DELAY, WRITE, READ, DRAIN};
  assign done      = state == FINISH;
  assign pass      = done && err_count == 16'd0;
  // next-state and next request/counter values; request fields only move on acceptance
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    idx_n   = idx;
    rcnt_n  = resp_take ? rcnt + 16'd1 : rcnt;
    outst_n = outst + {3'b0, rd_acc} - {3'b0, resp_take};
    val_n   = mem_req_val;
    rw_n    = mem_req_rw;
    addr_n  = mem_req_addr;
    data_n  = mem_req_data;
    err_n   = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    fea_n   = (mismatch && err_count == 16'd0) ? base_r + ADDR_W'(rcnt) : first_err_addr;
    mode_n  = mode_r;
    base_n  = base_r;
    case (state)
      IDLE, FINISH: if (start) begin
        state_n = DELAY;
        dcnt_n  = '0;
        idx_n   = '0;
        rcnt_n  = '0;
        outst_n = '0;
        err_n   = '0;
        fea_n   = '0;
        mode_n  = mode;
        base_n  = base_addr;
      end
      DELAY: if (dcnt == DW'(START_DELAY)) begin
        state_n = WRITE;
        idx_n   = '0;
        val_n   = 1'b1;
        rw_n    = 1'b1;
        addr_n  = base_r;
        data_n  = pat(mode_r, 16'd0);
      end else dcnt_n = dcnt + DW'(1);
      WRITE: if (acc) begin
        idx_n   = last_i ? 16'd0 : idx + 16'd1;
        state_n = last_i ? READ : WRITE;
        rw_n    = !last_i;
        addr_n  = base_r + ADDR_W'(idx_n);
        data_n  = last_i ? '0 : pat(mode_r, idx_n);
      end
      READ: begin
        if (acc && last_i) begin
          state_n = DRAIN;
          val_n   = 1'b0;
        end else if (acc || !mem_req_val) begin
          idx_n  = idx + {15'd0, acc};
          addr_n = base_r + ADDR_W'(idx_n);
          val_n  = outst_n < 4'(MAX_OUT);
        end
      end
      DRAIN: if ((resp_take && rcnt == LAST) || rcnt == 16'(NUM_LINES)) state_n = FINISH;
      default: state_n = IDLE;
    endcase
  end
  // state, request and result registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dcnt           <= '0;
      idx            <= '0;
      rcnt           <= '0;
      outst          <= '0;
      mem_req_val    <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      mode_r         <= '0;
      base_r         <= '0;
    end else begin
      state          <= state_n;
      dcnt           <= dcnt_n;
      idx            <= idx_n;
      rcnt           <= rcnt_n;
      outst          <= outst_n;
      mem_req_val    <= val_n;
      mem_req_rw     <= rw_n;
      mem_req_addr   <= addr_n;
      mem_req_data   <= data_n;
      err_count      <= err_n;
      first_err_addr <= fea_n;
      mode_r         <= mode_n;
      base_r         <= base_n;
    end
  end
endmodule

// File: tb/tb_dram_pattern_tester.sv
// tb_dram_pattern_tester: scoreboard bench with a behavioural memory for dram_pattern_tester
module tb_dram_pattern_tester;
  logic clk, rst_n, start;
  logic [1:0] mode;
  logic [25:0] base_addr, mem_req_addr, first_err_addr;
  logic mem_req_val, mem_req_rdy, mem_req_rw, mem_resp_val, busy, done, pass;
  logic [63:0] mem_req_data, mem_resp_data;
  logic [15:0] err_count;

  typedef struct { logic rw; logic [25:0] addr; logic [63:0] data; } req_t;
  typedef struct { logic p; logic [15:0] e; logic [25:0] f; } res_t;
  typedef struct { int due; logic [25:0] addr; } rd_t;
  req_t exp_q[$];
  res_t res_q[$];
  rd_t pipe[$];
  logic [63:0] mem [logic [25:0]];

  int cyc = 0, checks = 0, errors = 0, lat = 1;
  bit rand_rdy = 0, corrupt = 0, done_seen = 0;
  int first_val_cyc, first_resp_cyc, third_rd_cyc, acc_cnt, rd_cnt, resp_cnt, max_out;

  dram_pattern_tester #(.ADDR_W(26), .DATA_W(64), .NUM_LINES(4), .START_DELAY(3),
                        .MAX_OUT(2), .SEED(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " pass"}, pass, 0);
    chk({nm, " req_val"}, mem_req_val, 0);
    chk({nm, " req_rw"}, mem_req_rw, 0);
    chk({nm, " req_addr"}, mem_req_addr, 0);
    chk({nm, " req_data"}, mem_req_data, 0);
    chk({nm, " err_count"}, err_count, 0);
    chk({nm, " first_err_addr"}, first_err_addr, 0);
  endtask

  function automatic logic [3:0][63:0] rep4(input logic [31:0] w0, w1, w2, w3);
    return {{2{w3}}, {2{w2}}, {2{w1}}, {2{w0}}};
  endfunction

  // memory side: ready pattern and in-order read responses after lat cycles
  initial begin
    rd_t p;
    mem_req_rdy = 1;
    mem_resp_val = 0;
    mem_resp_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        pipe.delete();
        mem_req_rdy = 1;
        mem_resp_val = 0;
        mem_resp_data = '0;
        continue;
      end
      mem_req_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        p = pipe.pop_front();
        mem_resp_val = 1;
        mem_resp_data = (mem.exists(p.addr) ? mem[p.addr] : 64'h0) ^ ((corrupt && p.addr == 26'd3) ? 64'h1 : 64'h0);
      end else begin
        mem_resp_val = 0;
        mem_resp_data = '0;
      end
    end
  end

  // monitor: pops expected requests on acceptance and expected results on done
  initial begin
    req_t e;
    res_t r;
    rd_t p;
    bit stall = 0, prev_done = 0;
    logic prw;
    logic [25:0] paddr;
    logic [63:0] pdata;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
        prev_done = 0;
        continue;
      end
      if (stall) begin
        chk("hold val", mem_req_val, 1);
        chk("hold rw", mem_req_rw, prw);
        chk("hold addr", mem_req_addr, paddr);
        chk("hold data", mem_req_data, pdata);
      end
      if (mem_req_val && first_val_cyc < 0) first_val_cyc = cyc;
      if (mem_req_val && !mem_req_rw && rd_cnt == 2 && third_rd_cyc < 0) third_rd_cyc = cyc;
      if (mem_resp_val) begin
        resp_cnt++;
        if (first_resp_cyc < 0) first_resp_cyc = cyc;
      end
      if (mem_req_val && mem_req_rdy) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req extra: got addr %h rw %0d required none", mem_req_addr, mem_req_rw);
        end else begin
          e = exp_q.pop_front();
          chk("req rw", mem_req_rw, e.rw);
          chk("req addr", mem_req_addr, e.addr);
          if (e.rw) chk("req data", mem_req_data, e.data);
        end
        if (mem_req_rw) mem[mem_req_addr] = mem_req_data;
        else begin
          rd_cnt++;
          p.due = cyc + lat;
          p.addr = mem_req_addr;
          pipe.push_back(p);
        end
      end
      if (rd_cnt - resp_cnt > max_out) max_out = rd_cnt - resp_cnt;
      stall = mem_req_val && !mem_req_rdy;
      prw = mem_req_rw;
      paddr = mem_req_addr;
      pdata = mem_req_data;
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done extra: got done 1 required 0");
        end else begin
          r = res_q.pop_front();
          chk("result pass", pass, r.p);
          chk("result err_count", err_count, r.e);
          chk("result first_err_addr", first_err_addr, r.f);
        end
        done_seen = 1;
      end
      prev_done = done;
    end
  end

  task automatic clear_track();
    first_val_cyc = -1;
    first_resp_cyc = -1;
    third_rd_cyc = -1;
    acc_cnt = 0;
    rd_cnt = 0;
    resp_cnt = 0;
    max_out = 0;
    done_seen = 0;
  endtask

  task automatic push_exp(input logic [25:0] base, input logic [3:0][63:0] d);
    req_t r;
    for (int i = 0; i < 8; i++) begin
      r.rw = i < 4;
      r.addr = base + 26'(i % 4);
      r.data = i < 4 ? d[i] : 64'h0;
      exp_q.push_back(r);
    end
  endtask

  task automatic issue_start(input logic [1:0] m, input logic [25:0] base, output int sc);
    @(posedge clk);
    #1;
    start = 1;
    mode = m;
    base_addr = base;
    sc = cyc;
    @(posedge clk);
    #1;
    start = 0;
    mode = m ^ 2'd1;
    base_addr = '0;
  endtask

  task automatic run_pass(input string nm, input logic [1:0] m, input logic [25:0] base,
                          input logic [3:0][63:0] d, input logic ep, input logic [15:0] ee,
                          input logic [25:0] ef, input bit spur);
    res_t r;
    int sc;
    clear_track();
    push_exp(base, d);
    r.p = ep;
    r.e = ee;
    r.f = ef;
    res_q.push_back(r);
    issue_start(m, base, sc);
    if (spur) begin
      repeat (6) @(posedge clk);
      #1;
      start = 1;
      mode = 2'd1;
      base_addr = 26'h100;
      @(posedge clk);
      #1;
      start = 0;
      base_addr = '0;
    end
    for (int k = 0; k < 600 && !done_seen; k++) @(negedge clk);
    chk({nm, " done reached"}, done_seen, 1);
    chk({nm, " first write delay"}, 64'(first_val_cyc - sc - 1), 4);
    chk({nm, " requests left"}, exp_q.size(), 0);
    chk({nm, " acceptances"}, acc_cnt, 8);
    repeat (3) @(negedge clk);
    chk({nm, " done held"}, done, 1);
    chk({nm, " busy after done"}, busy, 0);
    chk({nm, " pass held"}, pass, ep);
  endtask

  initial begin
    int sc;
    rst_n = 0;
    start = 0;
    mode = 0;
    base_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1;
    run_pass("ideal", 2'd0, 26'd1, rep4(32'd0, 32'd1, 32'd2, 32'd3), 1, 16'd0, 26'd0, 0);
    corrupt = 1;
    run_pass("corrupt", 2'd0, 26'd1, rep4(32'd0, 32'd1, 32'd2, 32'd3), 0, 16'd1, 26'd3, 0);
    corrupt = 0;
    lat = 10;
    run_pass("latency", 2'd3, 26'd1, rep4(32'h0, 32'h9E3779B9, 32'h3C6EF372, 32'hDAA66D2B), 1, 16'd0, 26'd0, 0);
    chk("latency max outstanding", max_out, 2);
    chk("latency third read after first resp", third_rd_cyc >= 0 && third_rd_cyc >= first_resp_cyc, 1);
    lat = 1;
    rand_rdy = 1;
    run_pass("random rdy", 2'd2, 26'd1, rep4(32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC), 1, 16'd0, 26'd0, 1);
    rand_rdy = 0;
    run_pass("wrap", 2'd0, 26'h3FFFFFE, rep4(32'd0, 32'd1, 32'd2, 32'd3), 1, 16'd0, 26'd0, 0);
    clear_track();
    push_exp(26'd1, rep4(32'd0, 32'd1, 32'd2, 32'd3));
    issue_start(2'd0, 26'd1, sc);
    for (int k = 0; k < 100 && !(mem_req_val && !mem_req_rw); k++) @(negedge clk);
    chk("abort reached read", mem_req_val && !mem_req_rw, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk_reset("mid reset");
    exp_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    chk_reset("mid reset hold");
    @(posedge clk);
    #1;
    rst_n = 1;
    run_pass("after reset", 2'd1, 26'd1, {64'h8, 64'h4, 64'h2, 64'h1}, 1, 16'd0, 26'd0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
